// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the memory responder and the main controller.
// Contents: load/store size codes (funct3), memory FSM state encoding, the
// captured request payload, and small size-code helper functions.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WAIT_W   = 4;

    // RV32I load/store funct3 size codes
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } mem_state_e;

    // Request fields held for the duration of one access
    typedef struct packed {
        logic            write;
        logic [XLEN-1:0] addr;
        logic [2:0]      funct3;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic f3_supported(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) mis = lo[0];
        if (f3 == F3_W)                    mis = (lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit word memory (purely combinational).
// Store side: byte enables and replicated write data from size + addr[1:0].
// Load side: lane select from the read word, then sign/zero extension.
// Ports:
//   funct3_i      size code
//   addr_lo_i     effective addr[1:0] (already aligned by the caller if needed)
//   wdata_i       right-aligned store data
//   rword_i       word read from the array
//   be_c_o        store byte enables
//   wdata_c_o     store data replicated onto all candidate lanes
//   rdata_c_o     aligned and extended load data (0 for unsupported codes)
module mem_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rword_i,
    output logic [3:0]      be_c_o,
    output logic [XLEN-1:0] wdata_c_o,
    output logic [XLEN-1:0] rdata_c_o
);

    logic [XLEN-1:0] shifted_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;

    // Store: size taken from funct3[1:0] so BU/HU codes map to B/H widths
    always_comb begin
        be_c_o    = 4'b0000;
        wdata_c_o = wdata_i;
        case (funct3_i[1:0])
            2'd0: begin
                be_c_o    = 4'b0001 << addr_lo_i;
                wdata_c_o = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                be_c_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_c_o = {2{wdata_i[15:0]}};
            end
            2'd2: begin
                be_c_o    = 4'b1111;
                wdata_c_o = wdata_i;
            end
            default: be_c_o = 4'b0000;
        endcase
    end

    // Load: shift selected lane to bit 0, then extend
    always_comb begin
        shifted_c = rword_i >> {addr_lo_i, 3'b000};
        byte_c    = shifted_c[7:0];
        half_c    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        rdata_c_o = '0;
        case (funct3_i)
            F3_B:    rdata_c_o = {{24{byte_c[7]}}, byte_c};
            F3_H:    rdata_c_o = {{16{half_c[15]}}, half_c};
            F3_W:    rdata_c_o = rword_i;
            F3_BU:   rdata_c_o = {24'd0, byte_c};
            F3_HU:   rdata_c_o = {16'd0, half_c};
            default: rdata_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Unified instruction/data memory responder with fixed access latency.
// One request in flight: IDLE accepts, ACCESS waits WAIT_CYCLES extra cycles,
// RESPOND presents a one-cycle response pulse. Stores commit on ACCESS->RESPOND.
// Optional macro MEM_RESPONDER_MISALIGN_CHECK_EN: misaligned H/W faults instead
// of being silently aligned down.
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready handshake; req_write, req_addr, req_funct3, req_wdata
//   rsp_valid (pulse), rsp_rdata, rsp_err; busy = not IDLE
module mem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    mem_req_t          hold_q, hold_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

    logic [29:0]       widx_c;
    logic [IDX_W-1:0]  idx_c;
    logic              oob_c;
    logic              mis_err_c;
    logic              acc_err_c;
    logic [1:0]        lo_eff_c;
    logic              mem_we_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_rep_c;
    logic [XLEN-1:0]   load_c;

    assign widx_c    = hold_q.addr[31:2];
    assign idx_c     = widx_c[IDX_W-1:0];
    assign oob_c     = (32'(widx_c) >= 32'(DEPTH_WORDS));

`ifdef MEM_RESPONDER_MISALIGN_CHECK_EN
    assign mis_err_c = f3_misaligned(hold_q.funct3, hold_q.addr[1:0]);
    assign lo_eff_c  = hold_q.addr[1:0];
`else
    assign mis_err_c = 1'b0;
    // Misaligned H/W silently rounded down to the natural boundary
    always_comb begin
        lo_eff_c = hold_q.addr[1:0];
        if ((hold_q.funct3 == F3_H) || (hold_q.funct3 == F3_HU)) lo_eff_c = {hold_q.addr[1], 1'b0};
        if (hold_q.funct3 == F3_W)                                lo_eff_c = 2'b00;
    end
`endif

    assign acc_err_c = oob_c || mis_err_c || !f3_supported(hold_q.funct3);

    mem_lane_align u_lane (
        .funct3_i  (hold_q.funct3),
        .addr_lo_i (lo_eff_c),
        .wdata_i   (hold_q.wdata),
        .rword_i   (mem_q[idx_c]),
        .be_c_o    (be_c),
        .wdata_c_o (wdata_rep_c),
        .rdata_c_o (load_c)
    );

    // Next-state, capture and response generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_we_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    hold_d  = '{write: req_write, addr: req_addr,
                                funct3: req_funct3, wdata: req_wdata};
                    cnt_d   = '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == WAIT_W'(WAIT_CYCLES)) begin
                    state_d     = ST_RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err_c;
                    rsp_rdata_d = (acc_err_c || hold_q.write) ? '0 : load_c;
                    mem_we_c    = hold_q.write && !acc_err_c;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is not reset; reset forces IDLE so an aborted store never commits
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
